// File: rtl/grf_wb.sv
// grf_wb: P6 writeback-stage general register file, two combinational read ports,
// W-to-D internal bypass and a one-cycle registered commit record.
// Optional macro GRF_TRACE_EN compiles a judge-format $display per committed write.
module grf_wb #(
  parameter int DW     = 32,
  parameter int AW     = 5,
  parameter int BYPASS = 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          RegWrite_W,
  input  logic [AW-1:0] WR_W,
  input  logic [DW-1:0] WD_W,
  input  logic [31:0]   PC_W,
  input  logic [AW-1:0] A1,
  input  logic [AW-1:0] A2,
  output logic [DW-1:0] RD1,
  output logic [DW-1:0] RD2,
  output logic          commit_valid,
  output logic [31:0]   commit_pc,
  output logic [AW-1:0] commit_reg,
  output logic [DW-1:0] commit_data
);

  localparam int NREG = 2 ** AW;

  // Entry 0 is reset to zero and never written, so it folds away to a constant.
  logic [DW-1:0] regs_r [NREG];
  logic          write_en_s;
  logic          bypass_en_s;
  logic [DW-1:0] rd1_s;
  logic [DW-1:0] rd2_s;

  assign write_en_s  = RegWrite_W && (WR_W != {AW{1'b0}}) && !reset;
  assign bypass_en_s = (BYPASS != 0) && write_en_s;

  // Storage update; reset clears every entry and drops any concurrent write.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NREG; i++) regs_r[i] <= {DW{1'b0}};
    end else if (write_en_s) begin
      regs_r[WR_W] <= WD_W;
    end
  end

  // Read ports: r0 reads zero, same-cycle W write wins over stored data.
  always_comb begin
    rd1_s = {DW{1'b0}};
    rd2_s = {DW{1'b0}};
    if (A1 == {AW{1'b0}})                   rd1_s = {DW{1'b0}};
    else if (bypass_en_s && (WR_W == A1))   rd1_s = WD_W;
    else                                    rd1_s = regs_r[A1];
    if (A2 == {AW{1'b0}})                   rd2_s = {DW{1'b0}};
    else if (bypass_en_s && (WR_W == A2))   rd2_s = WD_W;
    else                                    rd2_s = regs_r[A2];
  end

  assign RD1 = rd1_s;
  assign RD2 = rd2_s;

  // Commit record: one-cycle valid pulse, payload holds until the next commit.
  always_ff @(posedge clk) begin
    if (reset) begin
      commit_valid <= 1'b0;
      commit_pc    <= 32'h0000_0000;
      commit_reg   <= {AW{1'b0}};
      commit_data  <= {DW{1'b0}};
    end else begin
      commit_valid <= write_en_s;
      if (write_en_s) begin
        commit_pc   <= PC_W;
        commit_reg  <= WR_W;
        commit_data <= WD_W;
      end else begin
        commit_pc   <= commit_pc;
        commit_reg  <= commit_reg;
        commit_data <= commit_data;
      end
    end
  end

`ifdef GRF_TRACE_EN
  // Judge-format trace of each committed write.
  always_ff @(posedge clk) begin
    if (write_en_s) begin
      $display("@%h: $%d <= %h", PC_W, WR_W, WD_W);
    end
  end
`endif

endmodule

// File: tb/tb_grf_wb.sv
// tb_grf_wb: scoreboard bench for grf_wb; a BYPASS=0 instance shares the inputs
// so the no-bypass read behaviour is checked alongside the default build.
module tb_grf_wb;

  typedef struct packed {
    logic        v;
    logic [31:0] pc;
    logic [4:0]  r;
    logic [31:0] d;
  } commit_t;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        RegWrite_W = 1'b0;
  logic [4:0]  WR_W = 5'd0;
  logic [31:0] WD_W = 32'h0;
  logic [31:0] PC_W = 32'h0;
  logic [4:0]  A1 = 5'd0;
  logic [4:0]  A2 = 5'd0;
  logic [31:0] RD1, RD2, commit_pc, commit_data;
  logic [4:0]  commit_reg;
  logic        commit_valid;
  logic [31:0] rd1_nb, rd2_nb, cpc_nb, cdata_nb;
  logic [4:0]  creg_nb;
  logic        cv_nb;

  int          total = 0;
  int          bad = 0;
  commit_t     exp_q[$];
  commit_t     mdl_commit;
  logic [31:0] mem [32];
  commit_t     e;
  commit_t     got;

  always #5 clk = ~clk;

  grf_wb #(.DW(32), .AW(5), .BYPASS(1)) dut (
    .clk(clk), .reset(reset), .RegWrite_W(RegWrite_W), .WR_W(WR_W), .WD_W(WD_W),
    .PC_W(PC_W), .A1(A1), .A2(A2), .RD1(RD1), .RD2(RD2),
    .commit_valid(commit_valid), .commit_pc(commit_pc),
    .commit_reg(commit_reg), .commit_data(commit_data)
  );

  grf_wb #(.DW(32), .AW(5), .BYPASS(0)) dut_nb (
    .clk(clk), .reset(reset), .RegWrite_W(RegWrite_W), .WR_W(WR_W), .WD_W(WD_W),
    .PC_W(PC_W), .A1(A1), .A2(A2), .RD1(rd1_nb), .RD2(rd2_nb),
    .commit_valid(cv_nb), .commit_pc(cpc_nb),
    .commit_reg(creg_nb), .commit_data(cdata_nb)
  );

  // Push the expected commit record for the current inputs, then clock once.
  task automatic step();
    if (reset) begin
      mdl_commit = '0;
      for (int i = 0; i < 32; i++) mem[i] = 32'h0;
    end else if (RegWrite_W && WR_W != 5'd0) begin
      mdl_commit = {1'b1, PC_W, WR_W, WD_W};
      mem[WR_W] = WD_W;
    end else begin
      mdl_commit.v = 1'b0;
    end
    exp_q.push_back(mdl_commit);
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; RegWrite_W = 1'b0; A1 = 5'd5; A2 = 5'd31;
    for (int c = 0; c < 3; c++) begin
      if (c == 2) reset = 1'b0;
      step();
      e = exp_q.pop_front();
      got = {commit_valid, commit_pc, commit_reg, commit_data};
      total++;
      if (got !== e) begin bad++; $display("FAIL reset_commit c=%0d got=%h exp=%h", c, got, e); end
      total++;
      if (RD1 !== 32'h0 || RD2 !== 32'h0) begin
        bad++; $display("FAIL reset_read c=%0d got=%h/%h exp=0/0", c, RD1, RD2);
      end
    end
  endtask

  task automatic test_write_bypass();
    RegWrite_W = 1'b1; WR_W = 5'd8; WD_W = 32'h1234_5678; PC_W = 32'h0000_3000; A1 = 5'd8; A2 = 5'd0;
    #1;
    total++;
    if (RD1 !== 32'h1234_5678) begin bad++; $display("FAIL bypass_rd1 got=%h exp=12345678", RD1); end
    total++;
    if (rd1_nb !== 32'h0) begin bad++; $display("FAIL nobypass_rd1 got=%h exp=0", rd1_nb); end
    step();
    e = exp_q.pop_front();
    got = {commit_valid, commit_pc, commit_reg, commit_data};
    total++;
    if (got !== e || got !== {1'b1, 32'h0000_3000, 5'd8, 32'h1234_5678}) begin
      bad++; $display("FAIL write_commit got=%h exp=%h", got, e);
    end
    RegWrite_W = 1'b0;
    #1;
    total++;
    if (RD1 !== 32'h1234_5678) begin bad++; $display("FAIL stored_rd1 got=%h exp=12345678", RD1); end
    step();
    e = exp_q.pop_front();
    got = {commit_valid, commit_pc, commit_reg, commit_data};
    total++;
    if (got !== e) begin bad++; $display("FAIL commit_hold got=%h exp=%h", got, e); end
  endtask

  task automatic test_write_zero();
    RegWrite_W = 1'b1; WR_W = 5'd0; WD_W = 32'hFFFF_FFFF; A1 = 5'd0; A2 = 5'd0;
    #1;
    total++;
    if (RD1 !== 32'h0 || RD2 !== 32'h0) begin bad++; $display("FAIL r0_read got=%h/%h exp=0/0", RD1, RD2); end
    step();
    e = exp_q.pop_front();
    got = {commit_valid, commit_pc, commit_reg, commit_data};
    total++;
    if (got !== e || commit_valid !== 1'b0) begin bad++; $display("FAIL r0_commit got=%h exp=%h", got, e); end
    RegWrite_W = 1'b0;
  endtask

  task automatic test_back_to_back();
    A1 = 5'd3; A2 = 5'd3; RegWrite_W = 1'b1; WR_W = 5'd3;
    for (int k = 0; k < 3; k++) begin
      if (k == 2) RegWrite_W = 1'b0;
      else begin WD_W = (k == 0) ? 32'hA : 32'hB; PC_W = 32'h3004 + 32'(k * 4); end
      #1;
      total++;
      if (RD1 !== ((k == 0) ? 32'hA : 32'hB) || RD2 !== RD1) begin
        bad++; $display("FAIL b2b_read k=%0d got=%h/%h exp=%h", k, RD1, RD2, (k == 0) ? 32'hA : 32'hB);
      end
      step();
      e = exp_q.pop_front();
      got = {commit_valid, commit_pc, commit_reg, commit_data};
      total++;
      if (got !== e) begin bad++; $display("FAIL b2b_commit k=%0d got=%h exp=%h", k, got, e); end
    end
  endtask

  task automatic test_reset_write();
    RegWrite_W = 1'b1; WR_W = 5'd9; WD_W = 32'h77; PC_W = 32'h3100;
    step();
    e = exp_q.pop_front();
    got = {commit_valid, commit_pc, commit_reg, commit_data};
    total++;
    if (got !== e) begin bad++; $display("FAIL pre_reset_commit got=%h exp=%h", got, e); end
    reset = 1'b1; WR_W = 5'd4; WD_W = 32'h55; A1 = 5'd4; A2 = 5'd9;
    #1;
    total++;
    if (RD1 !== 32'h0) begin bad++; $display("FAIL reset_bypass got=%h exp=0", RD1); end
    step();
    e = exp_q.pop_front();
    got = {commit_valid, commit_pc, commit_reg, commit_data};
    total++;
    if (got !== e || got !== '0) begin bad++; $display("FAIL reset_write_commit got=%h exp=%h", got, e); end
    reset = 1'b0; RegWrite_W = 1'b0;
    #1;
    total++;
    if (RD1 !== 32'h0 || RD2 !== 32'h0) begin bad++; $display("FAIL reset_clear got=%h/%h exp=0/0", RD1, RD2); end
    step();
    e = exp_q.pop_front();
    got = {commit_valid, commit_pc, commit_reg, commit_data};
    total++;
    if (got !== e) begin bad++; $display("FAIL post_reset_commit got=%h exp=%h", got, e); end
  endtask

  task automatic test_no_bypass();
    RegWrite_W = 1'b1; WR_W = 5'd6; WD_W = 32'h99; PC_W = 32'h3200; A1 = 5'd6; A2 = 5'd6;
    #1;
    total++;
    if (rd1_nb !== 32'h0 || RD1 !== 32'h99) begin
      bad++; $display("FAIL nb_same_cycle got nb=%h byp=%h exp 0/99", rd1_nb, RD1);
    end
    step();
    e = exp_q.pop_front();
    got = {cv_nb, cpc_nb, creg_nb, cdata_nb};
    total++;
    if (got !== e) begin bad++; $display("FAIL nb_commit got=%h exp=%h", got, e); end
    RegWrite_W = 1'b0;
    #1;
    total++;
    if (rd1_nb !== 32'h99 || rd2_nb !== 32'h99) begin bad++; $display("FAIL nb_next got=%h/%h exp=99", rd1_nb, rd2_nb); end
    step();
    void'(exp_q.pop_front());
  endtask

  task automatic test_random();
    logic [31:0] x1, x2, n1;
    for (int k = 0; k < 60; k++) begin
      RegWrite_W = 1'($urandom_range(1, 0));
      WR_W = 5'($urandom_range(31, 0));
      WD_W = $urandom();
      PC_W = 32'h3400 + 32'(k * 4);
      A1 = (k % 4 == 0) ? WR_W : 5'($urandom_range(31, 0));
      A2 = 5'($urandom_range(31, 0));
      #1;
      x1 = (A1 == 5'd0) ? 32'h0 : (RegWrite_W && WR_W == A1) ? WD_W : mem[A1];
      x2 = (A2 == 5'd0) ? 32'h0 : (RegWrite_W && WR_W == A2) ? WD_W : mem[A2];
      n1 = (A1 == 5'd0) ? 32'h0 : mem[A1];
      total++;
      if (RD1 !== x1 || RD2 !== x2 || rd1_nb !== n1) begin
        bad++; $display("FAIL rand_read k=%0d got=%h/%h/%h exp=%h/%h/%h", k, RD1, RD2, rd1_nb, x1, x2, n1);
      end
      step();
      e = exp_q.pop_front();
      got = {commit_valid, commit_pc, commit_reg, commit_data};
      total++;
      if (got !== e) begin bad++; $display("FAIL rand_commit k=%0d got=%h exp=%h", k, got, e); end
    end
    RegWrite_W = 1'b0;
  endtask

  initial begin
    mdl_commit = '0;
    for (int i = 0; i < 32; i++) mem[i] = 32'h0;
    #2;
    test_reset();
    test_write_bypass();
    test_write_zero();
    test_back_to_back();
    test_reset_write();
    test_no_bypass();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
